// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and state encoding for the instruction/data AXI3 read arbiter.
package axi_rd_arbiter_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

endpackage

// File: rtl/axi_rd_arbiter_cnt.sv
// Outstanding-read counter for one requester: saturating up/down with full and underflow flags.
module axi_out_cnt
    import axi_rd_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 4,
    localparam int CW = $clog2(MAX_OUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_underflow
);

    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_empty;

    assign w_full      = (r_cnt == CW'(MAX_OUT));
    assign w_empty     = (r_cnt == '0);
    assign o_full      = w_full;
    assign o_underflow = i_dec && w_empty;

    // A simultaneous issue and completion cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && !w_empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read master between instruction fetch (I) and memory stage (D).
// D has priority on AR, with a starvation guard for I; R beats are routed by RID.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_inst_araddr,
    input  logic [2:0]        i_inst_arsize,
    input  logic              i_inst_arvalid,
    output logic              o_inst_arready,
    output logic [DATA_W-1:0] o_inst_rdata,
    output logic              o_inst_rvalid,
    input  logic              i_inst_rready,
    input  logic [ADDR_W-1:0] i_data_araddr,
    input  logic [2:0]        i_data_arsize,
    input  logic              i_data_arvalid,
    output logic              o_data_arready,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic              o_data_rvalid,
    input  logic              i_data_rready,
    output logic [3:0]        o_m_arid,
    output logic [ADDR_W-1:0] o_m_araddr,
    output logic [2:0]        o_m_arsize,
    output logic              o_m_arvalid,
    input  logic              i_m_arready,
    input  logic [3:0]        i_m_rid,
    input  logic [DATA_W-1:0] i_m_rdata,
    input  logic              i_m_rlast,
    input  logic              i_m_rvalid,
    output logic              o_m_rready,
    output logic              o_rid_err
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    state_t            r_state;
    logic              r_arvalid;
    logic [3:0]        r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [2:0]        r_arsize;
    logic [SW-1:0]     r_starve;
    logic              r_rid_err;

    logic w_full_i, w_full_d, w_unf_i, w_unf_d;
    logic w_i_ok, w_d_ok, w_starved;
    logic w_ar_hs, w_inc_i, w_inc_d;
    logic w_sel_i, w_sel_d, w_bad_rid, w_rlast_hs, w_dec_i, w_dec_d;

    assign w_i_ok    = i_inst_arvalid && !w_full_i;
    assign w_d_ok    = i_data_arvalid && !w_full_d;
    assign w_starved = (r_starve == SW'(STARVE_LIM)) && w_i_ok;

    assign w_ar_hs = r_arvalid && i_m_arready;
    assign w_inc_i = w_ar_hs && (r_state == GNT_I);
    assign w_inc_d = w_ar_hs && (r_state == GNT_D);

    assign o_inst_arready = (r_state == GNT_I) && i_m_arready;
    assign o_data_arready = (r_state == GNT_D) && i_m_arready;
    assign o_m_arvalid    = r_arvalid;
    assign o_m_arid       = r_arid;
    assign o_m_araddr     = r_araddr;
    assign o_m_arsize     = r_arsize;

    // Unknown RIDs are accepted and dropped so the slave never stalls on them.
    assign w_sel_i    = (i_m_rid == ID_INST);
    assign w_sel_d    = (i_m_rid == ID_DATA);
    assign w_bad_rid  = !w_sel_i && !w_sel_d;
    assign o_m_rready = w_sel_i ? i_inst_rready : (w_sel_d ? i_data_rready : 1'b1);
    assign o_inst_rvalid = i_m_rvalid && w_sel_i;
    assign o_data_rvalid = i_m_rvalid && w_sel_d;
    assign o_inst_rdata  = i_m_rdata;
    assign o_data_rdata  = i_m_rdata;

    assign w_rlast_hs = i_m_rvalid && o_m_rready && i_m_rlast;
    assign w_dec_i    = w_rlast_hs && w_sel_i;
    assign w_dec_d    = w_rlast_hs && w_sel_d;
    assign o_rid_err  = r_rid_err;

    axi_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_i (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_inc_i),
        .i_dec       (w_dec_i),
        .o_full      (w_full_i),
        .o_underflow (w_unf_i)
    );

    axi_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_d (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_inc_d),
        .i_dec       (w_dec_d),
        .o_full      (w_full_d),
        .o_underflow (w_unf_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arsize  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_d_ok && !w_starved) begin
                        r_state   <= GNT_D;
                        r_arvalid <= 1'b1;
                        r_arid    <= ID_DATA;
                        r_araddr  <= i_data_araddr;
                        r_arsize  <= i_data_arsize;
                    end else if (w_i_ok) begin
                        r_state   <= GNT_I;
                        r_arvalid <= 1'b1;
                        r_arid    <= ID_INST;
                        r_araddr  <= i_inst_araddr;
                        r_arsize  <= i_inst_arsize;
                    end
                end
                GNT_I, GNT_D: begin
                    if (i_m_arready) begin
                        r_state   <= IDLE;
                        r_arvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Counts D grants that I had to watch go by; an I grant resets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_inc_i) begin
            r_starve <= '0;
        end else if (w_inc_d && i_inst_arvalid && (r_starve != SW'(STARVE_LIM))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rid_err <= 1'b0;
        end else if ((i_m_rvalid && w_bad_rid) || w_unf_i || w_unf_d) begin
            r_rid_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed scenarios followed by randomized traffic.
module tb_axi_rd_arbiter;

    localparam int MAX_OUT    = 4;
    localparam int STARVE_LIM = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_araddr, data_araddr, m_araddr, m_rdata, inst_rdata, data_rdata;
    logic [2:0]  inst_arsize, data_arsize, m_arsize;
    logic        inst_arvalid, inst_arready, inst_rvalid, inst_rready;
    logic        data_arvalid, data_arready, data_rvalid, data_rready;
    logic [3:0]  m_arid, m_rid;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, rid_err;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst),
        .i_inst_araddr(inst_araddr), .i_inst_arsize(inst_arsize), .i_inst_arvalid(inst_arvalid),
        .o_inst_arready(inst_arready), .o_inst_rdata(inst_rdata), .o_inst_rvalid(inst_rvalid),
        .i_inst_rready(inst_rready),
        .i_data_araddr(data_araddr), .i_data_arsize(data_arsize), .i_data_arvalid(data_arvalid),
        .o_data_arready(data_arready), .o_data_rdata(data_rdata), .o_data_rvalid(data_rvalid),
        .i_data_rready(data_rready),
        .o_m_arid(m_arid), .o_m_araddr(m_araddr), .o_m_arsize(m_arsize), .o_m_arvalid(m_arvalid),
        .i_m_arready(m_arready), .i_m_rid(m_rid), .i_m_rdata(m_rdata), .i_m_rlast(m_rlast),
        .i_m_rvalid(m_rvalid), .o_m_rready(m_rready), .o_rid_err(rid_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard queues: expected read data per requester, accepted AR IDs for the slave, grant log.
    logic [31:0] q_i[$];
    logic [31:0] q_d[$];
    logic [3:0]  ar_q[$];
    logic [3:0]  glog[$];
    int          gtime[$];

    // Reference model state (what the arbiter should be doing, by the rules).
    bit          m_busy, m_err, nb, i_ok, d_ok;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
    int          mc_i, mc_d, m_starve, inc_i, inc_d, dec_i, dec_d;
    int          cyc_n, n_iready, n_irvalid;
    bit          hs_i, hs_d, hs_r;
    logic [31:0] exp_data;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_err = 0; mc_i = 0; mc_d = 0; m_starve = 0;
            cyc_n = 0; n_iready = 0; n_irvalid = 0;
            hs_i = 0; hs_d = 0; hs_r = 0;
            q_i.delete(); q_d.delete(); ar_q.delete(); glog.delete(); gtime.delete();
        end else begin
            cyc_n++;
            hs_i = inst_arvalid && inst_arready;
            hs_d = data_arvalid && data_arready;
            hs_r = m_rvalid && m_rready;
            if (inst_arready) n_iready++;
            if (inst_rvalid)  n_irvalid++;

            chk("rid_err", rid_err, m_err);
            chk("m_arvalid", m_arvalid, m_busy);
            nb = m_busy; inc_i = 0; inc_d = 0; dec_i = 0; dec_d = 0;
            if (m_busy) begin
                chk("m_arid", m_arid, exp_id);
                chk("m_araddr", m_araddr, exp_addr);
                chk("m_arsize", m_arsize, exp_size);
                chk("inst_arready", inst_arready, (exp_id == 4'd0) && m_arready);
                chk("data_arready", data_arready, (exp_id == 4'd1) && m_arready);
                if (m_arready) begin
                    nb = 0;
                    glog.push_back(exp_id);
                    gtime.push_back(cyc_n);
                    ar_q.push_back(exp_id);
                    if (exp_id == 4'd0) inc_i = 1; else inc_d = 1;
                end
            end else begin
                chk("arready_idle", {inst_arready, data_arready}, 2'b00);
                i_ok = inst_arvalid && (mc_i < MAX_OUT);
                d_ok = data_arvalid && (mc_d < MAX_OUT);
                if (d_ok && !(m_starve == STARVE_LIM && i_ok)) begin
                    nb = 1; exp_id = 4'd1; exp_addr = data_araddr; exp_size = data_arsize;
                end else if (i_ok) begin
                    nb = 1; exp_id = 4'd0; exp_addr = inst_araddr; exp_size = inst_arsize;
                end
            end

            if (m_rvalid && m_rid == 4'd0) begin
                chk("route_i", {inst_rvalid, data_rvalid, m_rready}, {2'b10, inst_rready});
                if (inst_rready) begin
                    if (q_i.size() == 0) chk("inst_rdata_unexpected", 1, 0);
                    else begin exp_data = q_i.pop_front(); chk("inst_rdata", inst_rdata, exp_data); end
                    if (m_rlast) dec_i = 1;
                end
            end else if (m_rvalid && m_rid == 4'd1) begin
                chk("route_d", {inst_rvalid, data_rvalid, m_rready}, {2'b01, data_rready});
                if (data_rready) begin
                    if (q_d.size() == 0) chk("data_rdata_unexpected", 1, 0);
                    else begin exp_data = q_d.pop_front(); chk("data_rdata", data_rdata, exp_data); end
                    if (m_rlast) dec_d = 1;
                end
            end else if (m_rvalid) begin
                chk("route_bad", {inst_rvalid, data_rvalid, m_rready}, 3'b001);
                m_err = 1;
            end else begin
                chk("rvalid_idle", {inst_rvalid, data_rvalid}, 2'b00);
            end

            if ((dec_i && mc_i == 0) || (dec_d && mc_d == 0)) m_err = 1;
            mc_i = mc_i + inc_i - dec_i; if (mc_i < 0) mc_i = 0;
            mc_d = mc_d + inc_d - dec_d; if (mc_d < 0) mc_d = 0;
            if (inc_i) m_starve = 0;
            else if (inc_d && inst_arvalid && m_starve < STARVE_LIM) m_starve++;
            m_busy = nb;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int r_left;

    task automatic do_reset();
        rst = 1'b1;
        inst_araddr = '0; inst_arsize = '0; inst_arvalid = 0; inst_rready = 0;
        data_araddr = '0; data_arsize = '0; data_arvalid = 0; data_rready = 0;
        m_arready = 0; m_rid = '0; m_rdata = '0; m_rlast = 0; m_rvalid = 0;
        r_left = 0;
        #1;
        chk("rst_ar", {m_arvalid, inst_arready, data_arready}, 3'b000);
        chk("rst_arfields", {m_arid, m_araddr, m_arsize}, '0);
        chk("rst_rid_err", rid_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Keep requesters driven until n grants have been logged since reset.
    task automatic drive_grants(input bit i_keep, input bit d_keep, input int n);
        int t;
        t = 0;
        while (glog.size() < n && t < 100) begin
            cyc(1);
            t++;
            if (hs_i) begin
                if (i_keep) inst_araddr = $urandom; else inst_arvalid = 0;
            end
            if (hs_d) begin
                if (d_keep) data_araddr = $urandom; else data_arvalid = 0;
            end
        end
        if (glog.size() < n) chk("grant_timeout", glog.size(), n);
    endtask

    task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input bit last);
        int t;
        if (id == 4'd0) q_i.push_back(d);
        if (id == 4'd1) q_d.push_back(d);
        m_rid = id; m_rdata = d; m_rlast = last; m_rvalid = 1;
        t = 0;
        do begin cyc(1); t++; end while (!hs_r && t < 50);
        if (!hs_r) chk("beat_timeout", 0, 1);
        m_rvalid = 0; m_rlast = 0;
    endtask

    task automatic rand_step(input bit allow_req);
        if (hs_r) m_rvalid = 0;
        if (hs_i) inst_arvalid = 0;
        if (hs_d) data_arvalid = 0;
        if (allow_req && !inst_arvalid && $urandom_range(0, 99) < 40) begin
            inst_arvalid = 1; inst_araddr = $urandom; inst_arsize = 3'($urandom_range(0, 2));
        end
        if (allow_req && !data_arvalid && $urandom_range(0, 99) < 50) begin
            data_arvalid = 1; data_araddr = $urandom; data_arsize = 3'($urandom_range(0, 2));
        end
        m_arready   = ($urandom_range(0, 99) < 60);
        inst_rready = allow_req ? ($urandom_range(0, 99) < 70) : 1'b1;
        data_rready = allow_req ? ($urandom_range(0, 99) < 70) : 1'b1;
        if (!m_rvalid) begin
            if (ar_q.size() > 0 && $urandom_range(0, 99) < 50) begin
                if (r_left == 0) r_left = $urandom_range(1, 3);
                m_rid = ar_q[0]; m_rdata = $urandom; m_rlast = (r_left == 1);
                if (m_rid == 4'd0) q_i.push_back(m_rdata); else q_d.push_back(m_rdata);
                r_left--;
                if (r_left == 0) void'(ar_q.pop_front());
                m_rvalid = 1;
            end else if (allow_req && $urandom_range(0, 999) < 3) begin
                m_rid = 4'($urandom_range(2, 15)); m_rdata = $urandom;
                m_rlast = 1'($urandom_range(0, 1)); m_rvalid = 1;
            end
        end
    endtask

    initial begin
        int t;
        // Single I read with a late AR ready.
        do_reset();
        inst_arvalid = 1; inst_araddr = 32'h1FC0_0000; inst_arsize = 3'd2; inst_rready = 1;
        cyc(2);
        m_arready = 1;
        drive_grants(0, 0, 1);
        send_beat(4'd0, 32'h3C08_BFAF, 1);
        cyc(2);
        chk("p1_arready_pulses", n_iready, 1);
        chk("p1_rvalid_cycles", n_irvalid, 1);
        chk("p1_grant_id", glog[0], 4'd0);

        // Simultaneous requests: D first, I after one idle cycle.
        do_reset();
        m_arready = 1;
        inst_arvalid = 1; inst_araddr = 32'h1FC0_0010; inst_arsize = 3'd2;
        data_arvalid = 1; data_araddr = 32'h0000_1004; data_arsize = 3'd2;
        drive_grants(0, 0, 2);
        chk("p2_order", {glog[0], glog[1]}, 8'h10);
        chk("p2_gap", gtime[1] - gtime[0], 2);

        // Starvation guard: D, D, D, I, D.
        do_reset();
        m_arready = 1;
        inst_arvalid = 1; inst_araddr = $urandom; data_arvalid = 1; data_araddr = $urandom;
        drive_grants(1, 1, 5);
        chk("p3_seq", {glog[0], glog[1], glog[2], glog[3], glog[4]}, 20'h11101);

        // Full D blocks D but not I; one D completion unblocks D.
        do_reset();
        m_arready = 1; data_rready = 1;
        data_arvalid = 1; data_araddr = $urandom;
        drive_grants(0, 1, 4);
        cyc(6);
        chk("p4_full_block", glog.size(), 4);
        inst_arvalid = 1; inst_araddr = $urandom;
        drive_grants(0, 1, 5);
        chk("p4_i_granted", glog[4], 4'd0);
        send_beat(4'd1, $urandom, 1);
        drive_grants(0, 1, 6);
        chk("p4_d_after_last", glog[5], 4'd1);

        // Unknown RID: dropped, sticky error until reset.
        do_reset();
        inst_rready = 0; data_rready = 0;
        send_beat(4'd5, 32'hDEAD_BEEF, 1);
        cyc(4);
        chk("p5_rid_err_sticky", rid_err, 1);

        // Reset in GNT_D clears outputs at once; counters restart from zero.
        do_reset();
        m_arready = 1;
        data_arvalid = 1; data_araddr = $urandom;
        drive_grants(0, 1, 3);
        m_arready = 0;
        cyc(2);
        chk("p6_gnt_d", {m_arvalid, m_arid}, 5'h11);
        m_arready = 1;
        #1 chk("p6_arready_before", data_arready, 1);
        rst = 1;
        #1 chk("p6_async_clear", {m_arvalid, inst_arready, data_arready}, 3'b000);
        do_reset();
        m_arready = 1;
        data_arvalid = 1; data_araddr = $urandom;
        drive_grants(0, 1, 4);
        chk("p6_cnt_restart", glog.size(), 4);

        // Randomized traffic, then drain.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            rand_step(1);
        end
        t = 0;
        while ((ar_q.size() != 0 || m_rvalid || inst_arvalid || data_arvalid || m_busy) && t < 2000) begin
            cyc(1);
            rand_step(0);
            t++;
        end
        cyc(3);
        chk("drain_done", t < 2000, 1);
        chk("q_i_empty", q_i.size(), 0);
        chk("q_d_empty", q_d.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
